// File: rtl/timer_channel_sched.sv
// Shared prescaled timebase feeding NCH periodic/one-shot timer channels.
// Expiries are queued per channel and handed out round-robin on a valid/ready event port.
module timer_channel_sched #(
  parameter int PRESCALE = 50000,
  parameter int NCH      = 4,
  parameter int CH_W     = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cfg_we_i,
  input  logic [CH_W-1:0]  cfg_ch_i,
  input  logic             cfg_en_i,
  input  logic             cfg_oneshot_i,
  input  logic [CNT_W-1:0] cfg_period_i,
  output logic             base_tick_o,
  output logic [NCH-1:0]   ch_tick_o,
  output logic [NCH-1:0]   ch_active_o,
  output logic [NCH-1:0]   ch_overrun_o,
  output logic             evt_valid_o,
  output logic [CH_W-1:0]  evt_ch_o,
  input  logic             evt_ready_i
);

  localparam int              PS_W       = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_MAX     = PS_W'(PRESCALE - 1);
  localparam logic [0:0]      ST_IDLE    = 1'b0;
  localparam logic [0:0]      ST_PRESENT = 1'b1;

  logic [PS_W-1:0]  ps_q, ps_d;
  logic             tick_s;
  logic             base_tick_q;
  logic [CNT_W-1:0] cnt_q    [NCH];
  logic [CNT_W-1:0] cnt_d    [NCH];
  logic [CNT_W-1:0] period_q [NCH];
  logic [CNT_W-1:0] period_d [NCH];
  logic [NCH-1:0]   oneshot_q, oneshot_d;
  logic [NCH-1:0]   active_q, active_d;
  logic [NCH-1:0]   pending_q, pending_d;
  logic [NCH-1:0]   overrun_q, overrun_d;
  logic [NCH-1:0]   ch_tick_q, ch_tick_d;
  logic [0:0]       state_q, state_d;
  logic             evt_valid_q, evt_valid_d;
  logic [CH_W-1:0]  evt_ch_q, evt_ch_d;
  logic [CH_W-1:0]  last_q, last_d;
  logic [CH_W-1:0]  sel_s;
  logic [CH_W:0]    idx_s;
  logic             found_s;
  logic             grant_s;
  logic [NCH-1:0]   grant_vec_s;

  assign tick_s = (ps_q == PS_MAX);
  assign ps_d   = tick_s ? '0 : ps_q + PS_W'(1);

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    sel_s   = '0;
    found_s = 1'b0;
    idx_s   = '0;
    for (int i = 1; i <= NCH; i++) begin
      idx_s = {1'b0, last_q} + (CH_W+1)'(i);
      if (idx_s >= (CH_W+1)'(NCH)) idx_s = idx_s - (CH_W+1)'(NCH);
      else begin end
      if (!found_s && pending_q[idx_s[CH_W-1:0]]) begin
        found_s = 1'b1;
        sel_s   = idx_s[CH_W-1:0];
      end else begin end
    end
  end

  always_comb begin
    state_d     = state_q;
    evt_valid_d = evt_valid_q;
    evt_ch_d    = evt_ch_q;
    last_d      = last_q;
    grant_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          grant_s     = 1'b1;
          evt_valid_d = 1'b1;
          evt_ch_d    = sel_s;
          last_d      = sel_s;
          state_d     = ST_PRESENT;
        end else begin
          evt_valid_d = 1'b0;
        end
      end
      ST_PRESENT: begin
        if (evt_ready_i) begin
          evt_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          evt_valid_d = 1'b1;
        end
      end
      default: begin
        evt_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    grant_vec_s = '0;
    if (grant_s) grant_vec_s[sel_s] = 1'b1;
    else grant_vec_s = '0;
  end

  // Config beats expiry; an expiry re-pending a channel being granted is a fresh event, not an overrun.
  always_comb begin
    cnt_d     = cnt_q;
    period_d  = period_q;
    oneshot_d = oneshot_q;
    active_d  = active_q;
    overrun_d = overrun_q;
    pending_d = pending_q & ~grant_vec_s;
    ch_tick_d = '0;
    for (int c = 0; c < NCH; c++) begin
      if (cfg_we_i && (cfg_ch_i == CH_W'(c))) begin
        period_d[c]  = cfg_period_i;
        oneshot_d[c] = cfg_oneshot_i;
        cnt_d[c]     = cfg_period_i;
        active_d[c]  = cfg_en_i && (cfg_period_i != '0);
        pending_d[c] = 1'b0;
        overrun_d[c] = 1'b0;
      end else if (tick_s && active_q[c]) begin
        if (cnt_q[c] == CNT_W'(1)) begin
          ch_tick_d[c] = 1'b1;
          pending_d[c] = 1'b1;
          if (pending_q[c] && !grant_vec_s[c]) overrun_d[c] = 1'b1;
          else overrun_d[c] = overrun_q[c];
          if (oneshot_q[c]) active_d[c] = 1'b0;
          else cnt_d[c] = period_q[c];
        end else begin
          cnt_d[c] = cnt_q[c] - CNT_W'(1);
        end
      end else begin
        cnt_d[c] = cnt_q[c];
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ps_q        <= '0;
      base_tick_q <= 1'b0;
      oneshot_q   <= '0;
      active_q    <= '0;
      pending_q   <= '0;
      overrun_q   <= '0;
      ch_tick_q   <= '0;
      state_q     <= ST_IDLE;
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      last_q      <= CH_W'(NCH - 1);
      for (int c = 0; c < NCH; c++) begin
        cnt_q[c]    <= '0;
        period_q[c] <= '0;
      end
    end else begin
      ps_q        <= ps_d;
      base_tick_q <= tick_s;
      oneshot_q   <= oneshot_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      ch_tick_q   <= ch_tick_d;
      state_q     <= state_d;
      evt_valid_q <= evt_valid_d;
      evt_ch_q    <= evt_ch_d;
      last_q      <= last_d;
      for (int c = 0; c < NCH; c++) begin
        cnt_q[c]    <= cnt_d[c];
        period_q[c] <= period_d[c];
      end
    end
  end

  assign base_tick_o  = base_tick_q;
  assign ch_tick_o    = ch_tick_q;
  assign ch_active_o  = active_q;
  assign ch_overrun_o = overrun_q;
  assign evt_valid_o  = evt_valid_q;
  assign evt_ch_o     = evt_ch_q;

endmodule

// File: tb/tb_timer_channel_sched.sv
// Directed bench for timer_channel_sched with PRESCALE=4, NCH=4, CNT_W=8.
// Cycle Nn is the n-th falling edge after a falling edge that saw base_tick (N0).
module tb_timer_channel_sched;
  localparam int PRESCALE = 4;
  localparam int NCH      = 4;
  localparam int CH_W     = 2;
  localparam int CNT_W    = 8;

  logic             clk;
  logic             clr;
  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic             cfg_en;
  logic             cfg_oneshot;
  logic [CNT_W-1:0] cfg_period;
  logic             base_tick;
  logic [NCH-1:0]   ch_tick;
  logic [NCH-1:0]   ch_active;
  logic [NCH-1:0]   ch_overrun;
  logic             evt_valid;
  logic [CH_W-1:0]  evt_ch;
  logic             evt_ready;

  int tests;
  int fails;

  timer_channel_sched #(
    .PRESCALE(PRESCALE), .NCH(NCH), .CH_W(CH_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .clr(clr),
    .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch), .cfg_en_i(cfg_en),
    .cfg_oneshot_i(cfg_oneshot), .cfg_period_i(cfg_period),
    .base_tick_o(base_tick), .ch_tick_o(ch_tick), .ch_active_o(ch_active),
    .ch_overrun_o(ch_overrun), .evt_valid_o(evt_valid), .evt_ch_o(evt_ch),
    .evt_ready_i(evt_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired tests=%0d fails=%0d", tests, fails);
    $fatal(1);
  end

  task automatic cfg_set(input logic [CH_W-1:0] ch, input logic en, input logic os,
                         input logic [CNT_W-1:0] per);
    cfg_we = 1'b1; cfg_ch = ch; cfg_en = en; cfg_oneshot = os; cfg_period = per;
  endtask

  task automatic cfg_idle;
    cfg_we = 1'b0; cfg_ch = '0; cfg_en = 1'b0; cfg_oneshot = 1'b0; cfg_period = '0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic sync_tick(output bit ok);
    int i;
    ok = 1'b0;
    i  = 0;
    while (!ok && i < 16) begin
      @(negedge clk);
      if (base_tick === 1'b1) ok = 1'b1;
      i++;
    end
  endtask

  task automatic test_reset;
    bit ok;
    clr = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({base_tick, ch_tick, ch_active, ch_overrun, evt_valid, evt_ch} !== 16'h0) begin
      fails++; $display("FAIL reset_hold got=%h exp=0",
                        {base_tick, ch_tick, ch_active, ch_overrun, evt_valid, evt_ch});
    end
    clr = 1'b0;
    sync_tick(ok);
    tests++;
    if (ok !== 1'b1) begin fails++; $display("FAIL reset_sync got=%0b exp=1", ok); end
    cfg_set(2'd0, 1'b1, 1'b0, 8'd1);
    @(negedge clk);
    cfg_idle;
    repeat (5) @(negedge clk);
    tests++;
    if (ch_active !== 4'b0001) begin fails++; $display("FAIL reset_pre_active got=%b exp=0001", ch_active); end
    #2 clr = 1'b1;
    #1;
    tests++;
    if ({base_tick, ch_tick, ch_active, ch_overrun, evt_valid, evt_ch} !== 16'h0) begin
      fails++; $display("FAIL reset_async got=%h exp=0",
                        {base_tick, ch_tick, ch_active, ch_overrun, evt_valid, evt_ch});
    end
    @(negedge clk);
    clr = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      tests++;
      if (base_tick !== (n == 4)) begin
        fails++; $display("FAIL reset_resume n=%0d got=%b exp=%b", n, base_tick, (n == 4));
      end
    end
    tests++;
    if (ch_active !== 4'b0000) begin fails++; $display("FAIL reset_active got=%b exp=0000", ch_active); end
  endtask

  task automatic test_periodic;
    bit ok;
    logic [NCH-1:0] exp_tick;
    logic exp_valid;
    evt_ready = 1'b1;
    sync_tick(ok);
    tests++;
    if (ok !== 1'b1) begin fails++; $display("FAIL periodic_sync got=%0b exp=1", ok); end
    cfg_set(2'd0, 1'b1, 1'b0, 8'd3);
    @(negedge clk);
    cfg_idle;
    for (int n = 1; n <= 40; n++) begin
      exp_tick  = (n % 12 == 0) ? 4'b0001 : 4'b0000;
      exp_valid = (n % 12 == 1) && (n > 1);
      tests++;
      if (ch_tick !== exp_tick) begin
        fails++; $display("FAIL periodic_tick n=%0d got=%b exp=%b", n, ch_tick, exp_tick);
      end
      tests++;
      if (evt_valid !== exp_valid) begin
        fails++; $display("FAIL periodic_valid n=%0d got=%b exp=%b", n, evt_valid, exp_valid);
      end
      if (exp_valid) begin
        tests++;
        if (evt_ch !== 2'd0) begin fails++; $display("FAIL periodic_ch n=%0d got=%0d exp=0", n, evt_ch); end
      end
      @(negedge clk);
    end
    cfg_set(2'd0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    cfg_idle;
  endtask

  task automatic test_oneshot;
    bit ok;
    logic [NCH-1:0] exp_tick;
    logic [NCH-1:0] exp_act;
    logic exp_valid;
    sync_tick(ok);
    tests++;
    if (ok !== 1'b1) begin fails++; $display("FAIL oneshot_sync got=%0b exp=1", ok); end
    cfg_set(2'd1, 1'b1, 1'b1, 8'd2);
    @(negedge clk);
    cfg_idle;
    for (int n = 1; n <= 30; n++) begin
      exp_tick  = (n == 8) ? 4'b0010 : 4'b0000;
      exp_act   = (n < 8) ? 4'b0010 : 4'b0000;
      exp_valid = (n == 9);
      tests++;
      if (ch_tick !== exp_tick || ch_active !== exp_act || evt_valid !== exp_valid) begin
        fails++; $display("FAIL oneshot n=%0d got tick=%b act=%b vld=%b exp tick=%b act=%b vld=%b",
                          n, ch_tick, ch_active, evt_valid, exp_tick, exp_act, exp_valid);
      end
      if (n == 9) begin
        tests++;
        if (evt_ch !== 2'd1) begin fails++; $display("FAIL oneshot_ch got=%0d exp=1", evt_ch); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_round_robin;
    bit ok;
    int got;
    int cyc;
    logic [CH_W-1:0] exp_ch;
    do_reset;
    evt_ready = 1'b1;
    sync_tick(ok);
    tests++;
    if (ok !== 1'b1) begin fails++; $display("FAIL rr_sync got=%0b exp=1", ok); end
    for (int c = 0; c < NCH; c++) begin
      cfg_set(CH_W'(c), 1'b1, 1'b0, 8'd1);
      @(negedge clk);
    end
    cfg_idle;
    got = 0;
    cyc = 0;
    while (got < 8 && cyc < 200) begin
      if (evt_valid === 1'b1) begin
        exp_ch = CH_W'(got % NCH);
        tests++;
        if (evt_ch !== exp_ch) begin
          fails++; $display("FAIL rr_order grant=%0d got=%0d exp=%0d", got, evt_ch, exp_ch);
        end
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    tests++;
    if (got != 8) begin fails++; $display("FAIL rr_timeout grants got=%0d exp=8", got); end
  endtask

  task automatic test_overrun;
    bit ok;
    logic [NCH-1:0] exp_ovr;
    logic [NCH-1:0] exp_tick;
    do_reset;
    evt_ready = 1'b0;
    sync_tick(ok);
    tests++;
    if (ok !== 1'b1) begin fails++; $display("FAIL ovr_sync got=%0b exp=1", ok); end
    cfg_set(2'd2, 1'b1, 1'b0, 8'd1);
    @(negedge clk);
    cfg_idle;
    for (int n = 1; n <= 12; n++) begin
      exp_ovr  = (n >= 12) ? 4'b0100 : 4'b0000;
      exp_tick = (n % 4 == 0) ? 4'b0100 : 4'b0000;
      tests++;
      if (evt_valid !== (n >= 5) || ch_overrun !== exp_ovr || ch_tick !== exp_tick) begin
        fails++; $display("FAIL ovr n=%0d got vld=%b ovr=%b tick=%b exp vld=%b ovr=%b tick=%b",
                          n, evt_valid, ch_overrun, ch_tick, (n >= 5), exp_ovr, exp_tick);
      end
      if (n >= 5) begin
        tests++;
        if (evt_ch !== 2'd2) begin fails++; $display("FAIL ovr_ch n=%0d got=%0d exp=2", n, evt_ch); end
      end
      if (n < 12) @(negedge clk);
    end
    cfg_set(2'd2, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    cfg_idle;
    tests++;
    if (ch_overrun !== 4'b0000 || evt_valid !== 1'b1 || evt_ch !== 2'd2 || ch_active !== 4'b0000) begin
      fails++; $display("FAIL ovr_clear got ovr=%b vld=%b ch=%0d act=%b exp ovr=0000 vld=1 ch=2 act=0000",
                        ch_overrun, evt_valid, evt_ch, ch_active);
    end
    evt_ready = 1'b1;
    for (int n = 14; n <= 16; n++) begin
      @(negedge clk);
      tests++;
      if (evt_valid !== 1'b0) begin fails++; $display("FAIL ovr_drain n=%0d got=%b exp=0", n, evt_valid); end
    end
  endtask

  task automatic test_cfg_collision;
    bit ok;
    logic [NCH-1:0] exp_tick;
    do_reset;
    evt_ready = 1'b1;
    sync_tick(ok);
    tests++;
    if (ok !== 1'b1) begin fails++; $display("FAIL coll_sync got=%0b exp=1", ok); end
    cfg_set(2'd0, 1'b1, 1'b0, 8'd1);
    @(negedge clk);
    cfg_idle;
    for (int n = 1; n <= 7; n++) begin
      exp_tick = (n == 4) ? 4'b0001 : 4'b0000;
      tests++;
      if (ch_tick !== exp_tick) begin fails++; $display("FAIL coll_pre n=%0d got=%b exp=%b", n, ch_tick, exp_tick); end
      if (n < 7) @(negedge clk);
    end
    cfg_set(2'd0, 1'b1, 1'b0, 8'd5);
    @(negedge clk);
    cfg_idle;
    for (int n = 8; n <= 28; n++) begin
      exp_tick = (n == 28) ? 4'b0001 : 4'b0000;
      tests++;
      if (ch_tick !== exp_tick || ch_active !== 4'b0001) begin
        fails++; $display("FAIL coll_post n=%0d got tick=%b act=%b exp tick=%b act=0001",
                          n, ch_tick, ch_active, exp_tick);
      end
      if (n < 28) @(negedge clk);
    end
    cfg_set(2'd0, 1'b1, 1'b0, 8'd0);
    @(negedge clk);
    cfg_idle;
    tests++;
    if (ch_active !== 4'b0000) begin fails++; $display("FAIL coll_zero got=%b exp=0000", ch_active); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    clr = 1'b1;
    evt_ready = 1'b1;
    cfg_idle;
    test_reset;
    test_periodic;
    test_oneshot;
    test_round_robin;
    test_overrun;
    test_cfg_collision;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
